alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 214 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic/shift ops, plus iterative
// signed Booth multiply and signed restoring divide, one step per clock.
module alu_seq #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      clr,
   input  logic [DATA_WIDTH-1:0]     A,
   input  logic [DATA_WIDTH-1:0]     B,
   input  logic [4:0]                op,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic [2*DATA_WIDTH-1:0]   result,
   output logic                      div_zero,
   output logic                      bad_op
);

   // state | meaning
   // IDLE  | waiting for start; operands not yet latched
   // ITER  | one Booth or divide step per cycle, DATA_WIDTH steps
   // FIN   | register result and flags, pulse done, release busy

   localparam int W   = DATA_WIDTH;
   localparam int SHW = $clog2(W);
   localparam int CW  = $clog2(W + 1);

   localparam logic [4:0] OP_OR   = 5'd0;
   localparam logic [4:0] OP_AND  = 5'd1;
   localparam logic [4:0] OP_ADD  = 5'd2;
   localparam logic [4:0] OP_SUB  = 5'd3;
   localparam logic [4:0] OP_UADD = 5'd4;
   localparam logic [4:0] OP_MUL  = 5'd5;
   localparam logic [4:0] OP_DIV  = 5'd6;
   localparam logic [4:0] OP_SHR  = 5'd7;
   localparam logic [4:0] OP_SHRA = 5'd8;
   localparam logic [4:0] OP_SHL  = 5'd9;
   localparam logic [4:0] OP_ROR  = 5'd10;
   localparam logic [4:0] OP_ROL  = 5'd11;
   localparam logic [4:0] OP_NEG  = 5'd12;
   localparam logic [4:0] OP_NOT  = 5'd13;

   typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

   state_t            r_state;
   logic [W-1:0]      r_a;
   logic [W-1:0]      r_b;
   logic [4:0]        r_op;
   logic [W:0]        r_acc;
   logic [W-1:0]      r_q;
   logic              r_qm1;
   logic [CW-1:0]     r_cnt;
   logic              r_dz;
   logic              r_busy;
   logic              r_done;
   logic [2*W-1:0]    r_result;
   logic              r_div_zero;
   logic              r_bad_op;

   logic              w_accept;
   logic [W-1:0]      w_abs_a_in;
   logic [W-1:0]      w_abs_b;
   logic [W:0]        w_mcand;
   logic [W:0]        w_booth_sum;
   logic [W:0]        w_rem_sh;
   logic [W:0]        w_trial;
   logic [SHW-1:0]    w_amt;
   logic [2*W-1:0]    w_dbl;
   logic [W-1:0]      w_sra;
   logic [W-1:0]      w_ror;
   logic [W-1:0]      w_rol;
   logic [W-1:0]      w_quot;
   logic [W-1:0]      w_rem;
   logic [2*W-1:0]    w_fin_res;
   logic              w_fin_bad;

   // start coinciding with the done pulse is deliberately not accepted
   assign w_accept   = (r_state == IDLE) && start && !r_busy && !r_done;
   assign w_abs_a_in = A[W-1] ? -A : A;
   assign w_abs_b    = r_b[W-1] ? -r_b : r_b;

   // Booth accumulator is one bit wider so subtracting the most-negative
   // multiplicand cannot overflow.
   assign w_mcand = {r_a[W-1], r_a};
   always_comb begin
      w_booth_sum = r_acc;
      case ({r_q[0], r_qm1})
         2'b01:   w_booth_sum = r_acc + w_mcand;
         2'b10:   w_booth_sum = r_acc - w_mcand;
         default: w_booth_sum = r_acc;
      endcase
   end

   // Restoring divide on magnitudes; signs are applied in FIN.
   assign w_rem_sh = {r_acc[W-1:0], r_q[W-1]};
   assign w_trial  = w_rem_sh - {1'b0, w_abs_b};

   assign w_amt = r_b[SHW-1:0];
   assign w_dbl = {r_a, r_a};
   assign w_sra = $signed(r_a) >>> w_amt;
   assign w_ror = W'(w_dbl >> w_amt);
   assign w_rol = W'((w_dbl << w_amt) >> W);

   assign w_quot = (r_a[W-1] ^ r_b[W-1]) ? -r_q : r_q;
   assign w_rem  = r_a[W-1] ? -r_acc[W-1:0] : r_acc[W-1:0];

   always_comb begin
      w_fin_res = '0;
      w_fin_bad = 1'b0;
      case (r_op)
         OP_OR:   w_fin_res = {{W{1'b0}}, r_a | r_b};
         OP_AND:  w_fin_res = {{W{1'b0}}, r_a & r_b};
         OP_ADD:  w_fin_res = {{W{r_a[W-1]}}, r_a} + {{W{r_b[W-1]}}, r_b};
         OP_SUB:  w_fin_res = {{W{r_a[W-1]}}, r_a} - {{W{r_b[W-1]}}, r_b};
         OP_UADD: w_fin_res = {{W{1'b0}}, r_a} + {{W{1'b0}}, r_b};
         OP_MUL:  w_fin_res = {r_acc[W-1:0], r_q};
         OP_DIV:  w_fin_res = r_dz ? '0 : {w_rem, w_quot};
         OP_SHR:  w_fin_res = {{W{1'b0}}, r_a >> w_amt};
         OP_SHRA: w_fin_res = {{W{1'b0}}, w_sra};
         OP_SHL:  w_fin_res = {{W{1'b0}}, r_a << w_amt};
         OP_ROR:  w_fin_res = {{W{1'b0}}, w_ror};
         OP_ROL:  w_fin_res = {{W{1'b0}}, w_rol};
         OP_NEG:  w_fin_res = -{{W{r_a[W-1]}}, r_a};
         OP_NOT:  w_fin_res = {{W{1'b0}}, ~r_a};
         default: begin
            w_fin_res = '0;
            w_fin_bad = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state    <= IDLE;
         r_a        <= '0;
         r_b        <= '0;
         r_op       <= '0;
         r_acc      <= '0;
         r_q        <= '0;
         r_qm1      <= 1'b0;
         r_cnt      <= '0;
         r_dz       <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_result   <= '0;
         r_div_zero <= 1'b0;
         r_bad_op   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_a    <= A;
                  r_b    <= B;
                  r_op   <= op;
                  r_busy <= 1'b1;
                  r_acc  <= '0;
                  r_qm1  <= 1'b0;
                  r_cnt  <= CW'(W - 1);
                  r_dz   <= 1'b0;
                  if (op == OP_MUL) begin
                     r_q     <= B;
                     r_state <= ITER;
                  end else if (op == OP_DIV) begin
                     if (B == '0) begin
                        r_dz    <= 1'b1;
                        r_state <= FIN;
                     end else begin
                        r_q     <= w_abs_a_in;
                        r_state <= ITER;
                     end
                  end else begin
                     r_state <= FIN;
                  end
               end
            end
            ITER: begin
               if (r_op == OP_MUL) begin
                  r_acc <= {w_booth_sum[W], w_booth_sum[W:1]};
                  r_q   <= {w_booth_sum[0], r_q[W-1:1]};
                  r_qm1 <= r_q[0];
               end else if (!w_trial[W]) begin
                  r_acc <= w_trial;
                  r_q   <= {r_q[W-2:0], 1'b1};
               end else begin
                  r_acc <= w_rem_sh;
                  r_q   <= {r_q[W-2:0], 1'b0};
               end
               if (r_cnt == '0) begin
                  r_state <= FIN;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            FIN: begin
               r_result   <= w_fin_res;
               r_div_zero <= r_dz;
               r_bad_op   <= w_fin_bad;
               r_done     <= 1'b1;
               r_busy     <= 1'b0;
               r_state    <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign result   = r_result;
   assign div_zero = r_div_zero;
   assign bad_op   = r_bad_op;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (DATA_WIDTH=32): hand-computed results,
// latencies, flags, busy/start interaction and mid-operation reset.
module tb_alu_seq;

   localparam int DW = 32;

   logic            clk;
   logic            clr;
   logic [DW-1:0]   A;
   logic [DW-1:0]   B;
   logic [4:0]      op;
   logic            start;
   logic            busy;
   logic            done;
   logic [2*DW-1:0] result;
   logic            div_zero;
   logic            bad_op;

   int n_tot = 0;
   int n_bad = 0;

   alu_seq #(.DATA_WIDTH(DW)) u_dut (
      .clk      (clk),
      .clr      (clr),
      .A        (A),
      .B        (B),
      .op       (op),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .div_zero (div_zero),
      .bad_op   (bad_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
      n_tot++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
      end
   endtask

   // returns cycles from the accepting edge to done, and whether busy stayed high until then
   task automatic run_op(input logic [4:0] f_op, input logic [DW-1:0] f_a, input logic [DW-1:0] f_b,
                         output int lat, output logic busy_held);
      if (done) begin
         @(posedge clk); #1;
      end
      op = f_op; A = f_a; B = f_b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      busy_held = busy;
      while (!done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (!done) busy_held = busy_held & busy;
      end
   endtask

   task automatic check_op(input string tag, input logic [4:0] f_op, input logic [DW-1:0] f_a,
                           input logic [DW-1:0] f_b, input logic [2*DW-1:0] exp_res,
                           input logic exp_dz, input logic exp_bad, input int exp_lat);
      int   lat;
      logic bh;
      run_op(f_op, f_a, f_b, lat, bh);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_res"}, result, exp_res);
      chk({tag, "_dz"}, div_zero, exp_dz);
      chk({tag, "_bad"}, bad_op, exp_bad);
      chk({tag, "_busyheld"}, bh, 1'b1);
      chk({tag, "_busyend"}, busy, 1'b0);
   endtask

   initial begin
      int   lat;
      int   n_done;
      logic bh;

      clr = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_res", result, '0);
      chk("rst_dz", div_zero, 1'b0);
      chk("rst_bad", bad_op, 1'b0);
      clr = 1'b0;
      @(posedge clk); #1;

      check_op("add",   5'd2,  32'd5,        32'hFFFFFFFD, 64'h0000000000000002, 1'b0, 1'b0, 1);
      check_op("sub",   5'd3,  32'd3,        32'd5,        64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b0, 1);
      check_op("uadd",  5'd4,  32'hFFFFFFFF, 32'd1,        64'h0000000100000000, 1'b0, 1'b0, 1);
      check_op("or",    5'd0,  32'hF0F00000, 32'h0000000F, 64'h00000000F0F0000F, 1'b0, 1'b0, 1);
      check_op("mul",   5'd5,  32'hFFFFFFF9, 32'd6,        64'hFFFFFFFFFFFFFFD6, 1'b0, 1'b0, 33);
      check_op("mulmn", 5'd5,  32'h80000000, 32'h80000000, 64'h4000000000000000, 1'b0, 1'b0, 33);
      check_op("mulmx", 5'd5,  32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001, 1'b0, 1'b0, 33);
      check_op("div",   5'd6,  32'd17,       32'hFFFFFFFB, 64'h00000002FFFFFFFD, 1'b0, 1'b0, 33);
      check_op("divn",  5'd6,  32'hFFFFFFEF, 32'd5,        64'hFFFFFFFEFFFFFFFD, 1'b0, 1'b0, 33);
      check_op("divmn", 5'd6,  32'h80000000, 32'hFFFFFFFF, 64'h0000000080000000, 1'b0, 1'b0, 33);
      check_op("div0",  5'd6,  32'd9,        32'd0,        64'h0000000000000000, 1'b1, 1'b0, 1);
      check_op("and",   5'd1,  32'h0000F0F0, 32'h0000FF00, 64'h000000000000F000, 1'b0, 1'b0, 1);
      check_op("shr",   5'd7,  32'h80000000, 32'd4,        64'h0000000008000000, 1'b0, 1'b0, 1);
      check_op("shra",  5'd8,  32'h80000000, 32'd4,        64'h00000000F8000000, 1'b0, 1'b0, 1);
      check_op("shlw",  5'd9,  32'd1,        32'h00000021, 64'h0000000000000002, 1'b0, 1'b0, 1);
      check_op("ror",   5'd10, 32'h00000001, 32'd1,        64'h0000000080000000, 1'b0, 1'b0, 1);
      check_op("rol",   5'd11, 32'h80000001, 32'd1,        64'h0000000000000003, 1'b0, 1'b0, 1);
      check_op("neg",   5'd12, 32'd5,        32'd0,        64'hFFFFFFFFFFFFFFFB, 1'b0, 1'b0, 1);
      check_op("not",   5'd13, 32'd0,        32'd0,        64'h00000000FFFFFFFF, 1'b0, 1'b0, 1);
      check_op("badop", 5'd20, 32'd7,        32'd7,        64'h0000000000000000, 1'b0, 1'b1, 1);
      check_op("clrbd", 5'd0,  32'h00000010, 32'h00000001, 64'h0000000000000011, 1'b0, 1'b0, 1);

      // start pulsed mid-MUL must be ignored
      if (done) begin
         @(posedge clk); #1;
      end
      op = 5'd5; A = 32'd123; B = 32'hFFFFFFD3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      while (!done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 5) begin
            op = 5'd2; A = 32'd1; B = 32'd1; start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      chk("inj_lat", lat, 33);
      chk("inj_res", result, 64'hFFFFFFFFFFFFEA61);

      // start held across the done cycle: ignored then, accepted next cycle
      chk("dc_done", done, 1'b1);
      op = 5'd2; A = 32'd1; B = 32'd1; start = 1'b1;
      @(posedge clk); #1;
      chk("dc_ign", busy, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      chk("dc_acc", busy, 1'b1);
      @(posedge clk); #1;
      chk("dc_done2", done, 1'b1);
      chk("dc_res", result, 64'd2);

      // reset during ITER aborts the MUL with no done
      check_op("prebad", 5'd31, 32'd1, 32'd1, 64'd0, 1'b0, 1'b1, 1);
      run_op(5'd9, 32'd3, 32'd4, lat, bh);
      chk("preshl", result, 64'h30);
      @(posedge clk); #1;
      op = 5'd5; A = 32'hFFFFFFF9; B = 32'd6; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      chk("mid_busy", busy, 1'b1);
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      chk("clr_busy", busy, 1'b0);
      chk("clr_done", done, 1'b0);
      chk("clr_res", result, '0);
      chk("clr_dz", div_zero, 1'b0);
      n_done = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      chk("clr_nodone", n_done, 0);
      check_op("postclr", 5'd9, 32'd3, 32'd4, 64'h0000000000000030, 1'b0, 1'b0, 1);

      // clr wins over a simultaneous start
      @(posedge clk); #1;
      op = 5'd2; A = 32'd1; B = 32'd1; start = 1'b1; clr = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; clr = 1'b0;
      chk("clrpri_busy", busy, 1'b0);
      @(posedge clk); #1;
      chk("clrpri_done", done, 1'b0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
